// File: rtl/cpu_defs_pkg.sv
// Constants shared by the single-cycle and multi-cycle control units:
// opcodes, FSM state encodings, ALUOp codes and the decoded-instruction record.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLTZ  = 6'b000110;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_e;

    // ALU_FUNCT hands the operation choice to the funct field of an R-type word.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_SLT   = 4'b0100,
        ALU_FUNCT = 4'b1000
    } alu_op_e;

    typedef enum logic [2:0] {
        CLS_AL   = 3'd0,
        CLS_LS   = 3'd1,
        CLS_BR   = 3'd2,
        CLS_J    = 3'd3,
        CLS_HALT = 3'd4
    } ins_class_e;

    typedef struct packed {
        ins_class_e cls;
        alu_op_e    alu_op;
        logic       ext_src;
        logic       reg_dst;
        logic       is_lw;
        logic       br_on_zero;
    } decode_t;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Opcode/flag inputs and control outputs between the controller and the datapath.
interface multi_cycle_control_if #(
    parameter int ICNT_W = 16
);
    logic [5:0]        op;
    logic              zero;
    logic              PCWrite;
    logic [1:0]        PCSrc;
    logic              IRWrite;
    logic              InsMemRW;
    logic              ExtSrc;
    logic [3:0]        ALUOp;
    logic              MemRead;
    logic              MemWrite;
    logic              MemtoReg;
    logic              RegWrite;
    logic              RegDst;
    logic [2:0]        state;
    logic              halted;
    logic [ICNT_W-1:0] instr_count;

    modport master (
        input  op, zero,
        output PCWrite, PCSrc, IRWrite, InsMemRW, ExtSrc, ALUOp,
               MemRead, MemWrite, MemtoReg, RegWrite, RegDst,
               state, halted, instr_count
    );

    modport slave (
        output op, zero,
        input  PCWrite, PCSrc, IRWrite, InsMemRW, ExtSrc, ALUOp,
               MemRead, MemWrite, MemtoReg, RegWrite, RegDst,
               state, halted, instr_count
    );
endinterface

// File: rtl/multi_cycle_control_op_decode.sv
// Combinational opcode decode: instruction class plus ALUOp/ExtSrc/RegDst,
// using the same mapping as the single-cycle control unit.
module op_decode
    import cpu_defs::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT
) (
    input  logic [5:0] op_i,
    output decode_t    dec_o
);

    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned, which would infer a latch.
    always_comb begin
        dec_o = '{cls: CLS_HALT, alu_op: ALU_ADD, ext_src: 1'b1,
                  reg_dst: 1'b0, is_lw: 1'b0, br_on_zero: 1'b1};
        if (op_i != HALT_OP) begin
            case (op_i)
                OP_RTYPE: begin
                    dec_o.cls     = CLS_AL;
                    dec_o.alu_op  = ALU_FUNCT;
                    dec_o.reg_dst = 1'b1;
                end
                OP_ADDIU: dec_o.cls = CLS_AL;
                OP_ANDI: begin
                    dec_o.cls     = CLS_AL;
                    dec_o.alu_op  = ALU_AND;
                    dec_o.ext_src = 1'b0;
                end
                OP_ORI: begin
                    dec_o.cls     = CLS_AL;
                    dec_o.alu_op  = ALU_OR;
                    dec_o.ext_src = 1'b0;
                end
                OP_SLTI: begin
                    dec_o.cls    = CLS_AL;
                    dec_o.alu_op = ALU_SLT;
                end
                OP_LW: begin
                    dec_o.cls   = CLS_LS;
                    dec_o.is_lw = 1'b1;
                end
                OP_SW: dec_o.cls = CLS_LS;
                OP_BEQ: begin
                    dec_o.cls    = CLS_BR;
                    dec_o.alu_op = ALU_SUB;
                end
                OP_BNE: begin
                    dec_o.cls        = CLS_BR;
                    dec_o.alu_op     = ALU_SUB;
                    dec_o.br_on_zero = 1'b0;
                end
                OP_BLTZ: begin
                    dec_o.cls    = CLS_BR;
                    dec_o.alu_op = ALU_SLT;
                end
                OP_J: dec_o.cls = CLS_J;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB per instruction class,
// with a sticky HALT flag and a retired-instruction counter.
module multi_cycle_control
    import cpu_defs::*;
#(
    parameter int         ICNT_W  = 16,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input logic                   CLK,
    input logic                   Reset,
    multi_cycle_control_if.master bus
);

    state_e            state_q, state_d;
    logic              halt_q, halt_d;
    logic [ICNT_W-1:0] count_q, count_d;
    decode_t           dec;

    logic       pc_write, ir_write, ins_mem_rw, ext_src;
    logic       mem_read, mem_write, mem_to_reg, reg_write, reg_dst;
    logic [1:0] pc_src;
    alu_op_e    alu_op;
    logic       br_taken;

    op_decode #(.HALT_OP(HALT_OP)) u_op_decode (
        .op_i  (bus.op),
        .dec_o (dec)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IF;
            halt_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        if (!halt_q) begin
            case (state_q)
                ST_IF: state_d = ST_ID;
                ST_ID: begin
                    case (dec.cls)
                        CLS_J:   state_d = ST_IF;
                        CLS_BR:  state_d = ST_EXE_BR;
                        CLS_LS:  state_d = ST_EXE_LS;
                        CLS_AL:  state_d = ST_EXE_AL;
                        default: halt_d  = 1'b1;
                    endcase
                end
                ST_EXE_LS: state_d = ST_MEM;
                ST_MEM:    state_d = dec.is_lw ? ST_WB_LD : ST_IF;
                ST_EXE_AL: state_d = ST_WB_AL;
                ST_WB_LD,
                ST_EXE_BR,
                ST_WB_AL:  state_d = ST_IF;
                default:   state_d = ST_IF;
            endcase
        end
    end

    // beq/bltz take the branch on zero=1, bne on zero=0.
    assign br_taken = dec.br_on_zero ? bus.zero : ~bus.zero;

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = PCSRC_SEQ;
        ir_write   = 1'b0;
        ins_mem_rw = 1'b0;
        ext_src    = 1'b1;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        if (!halt_q) begin
            case (state_q)
                ST_IF: begin
                    ir_write   = 1'b1;
                    ins_mem_rw = 1'b1;
                end
                ST_ID: begin
                    if (dec.cls == CLS_J) begin
                        pc_write = 1'b1;
                        pc_src   = PCSRC_JMP;
                    end
                end
                ST_EXE_AL: begin
                    alu_op  = dec.alu_op;
                    ext_src = dec.ext_src;
                end
                ST_WB_AL: begin
                    reg_write = 1'b1;
                    reg_dst   = dec.reg_dst;
                    pc_write  = 1'b1;
                end
                ST_EXE_BR: begin
                    alu_op   = dec.alu_op;
                    ext_src  = dec.ext_src;
                    pc_write = 1'b1;
                    pc_src   = br_taken ? PCSRC_BR : PCSRC_SEQ;
                end
                ST_MEM: begin
                    if (dec.is_lw) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        pc_write  = 1'b1;
                    end
                end
                ST_WB_LD: begin
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    pc_write   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Reset has priority in the register, so the unmasked strobe is safe here.
    assign count_d = pc_write ? count_q + ICNT_W'(1) : count_q;

    assign bus.PCWrite     = pc_write  & ~Reset;
    assign bus.IRWrite     = ir_write  & ~Reset;
    assign bus.RegWrite    = reg_write & ~Reset;
    assign bus.MemWrite    = mem_write & ~Reset;
    assign bus.MemRead     = mem_read  & ~Reset;
    assign bus.PCSrc       = pc_src;
    assign bus.InsMemRW    = ins_mem_rw;
    assign bus.ExtSrc      = ext_src;
    assign bus.ALUOp       = alu_op;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.state       = state_q;
    assign bus.halted      = halt_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: table of instructions expanded
// into per-cycle expected outputs through a scoreboard, plus halt/reset/wrap sequences.
module tb_multi_cycle_control;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_LS = 3'd2, S_MEM = 3'd3;
    localparam logic [2:0] S_WBLD = 3'd4, S_BR = 3'd5, S_AL = 3'd6, S_WBAL = 3'd7;

    typedef struct packed {
        logic [2:0] state;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       irwrite;
        logic       insmem;
        logic       ext;
        logic [3:0] alu;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       regdst;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        int         n;
        logic [2:0] seq [5];
        logic [3:0] alu;
        logic       ext;
        logic [1:0] pcsrc;
        logic       regdst;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_cycle_control_if #(.ICNT_W(16)) bus ();
    multi_cycle_control_if #(.ICNT_W(2))  bus2 ();

    multi_cycle_control #(.ICNT_W(16), .HALT_OP(6'b111111)) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    multi_cycle_control #(.ICNT_W(2), .HALT_OP(6'b111111)) dut2 (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus2)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    ctl_t        sb [$];
    vec_t        vecs [$];
    logic [15:0] exp_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic z);
        bus.op    = op;
        bus.zero  = z;
        bus2.op   = op;
        bus2.zero = z;
    endtask

    function automatic ctl_t sample();
        ctl_t s;
        s.state    = bus.state;
        s.pcwrite  = bus.PCWrite;
        s.pcsrc    = bus.PCSrc;
        s.irwrite  = bus.IRWrite;
        s.insmem   = bus.InsMemRW;
        s.ext      = bus.ExtSrc;
        s.alu      = bus.ALUOp;
        s.memread  = bus.MemRead;
        s.memwrite = bus.MemWrite;
        s.memtoreg = bus.MemtoReg;
        s.regwrite = bus.RegWrite;
        s.regdst   = bus.RegDst;
        s.halted   = bus.halted;
        return s;
    endfunction

    // Expected outputs for cycle k of an instruction whose state path is in the table.
    function automatic ctl_t exp_cycle(input vec_t v, input int k);
        ctl_t e;
        e         = '0;
        e.ext     = 1'b1;
        e.state   = v.seq[k];
        e.pcwrite = (k == v.n - 1);
        case (e.state)
            S_IF: begin
                e.irwrite = 1'b1;
                e.insmem  = 1'b1;
            end
            S_ID: if (e.pcwrite) e.pcsrc = 2'b10;
            S_AL: begin
                e.alu = v.alu;
                e.ext = v.ext;
            end
            S_BR: begin
                e.alu   = v.alu;
                e.ext   = v.ext;
                e.pcsrc = v.pcsrc;
            end
            S_MEM: begin
                e.memread  = (v.op == 6'b100011);
                e.memwrite = (v.op == 6'b101011);
            end
            S_WBLD: begin
                e.memread  = 1'b1;
                e.memtoreg = 1'b1;
                e.regwrite = 1'b1;
            end
            S_WBAL: begin
                e.regwrite = 1'b1;
                e.regdst   = v.regdst;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic add(input logic [5:0] op, input logic z, input int n,
                       input logic [2:0] s2, input logic [2:0] s3, input logic [2:0] s4,
                       input logic [3:0] alu, input logic ext, input logic [1:0] pcsrc,
                       input logic rd);
        vec_t v;
        v.op = op; v.zero = z; v.n = n;
        v.seq[0] = S_IF; v.seq[1] = S_ID; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        v.alu = alu; v.ext = ext; v.pcsrc = pcsrc; v.regdst = rd;
        vecs.push_back(v);
    endtask

    task automatic run_cycles(input vec_t v, input int ncyc, input string name);
        ctl_t e;
        set_in(v.op, v.zero);
        for (int k = 0; k < ncyc; k++) sb.push_back(exp_cycle(v, k));
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("%s cyc%0d", name, k), 64'(sample()), 64'(e));
            if (k < ncyc - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        string name;
        name = $sformatf("op%b z%b", v.op, v.zero);
        run_cycles(v, v.n, name);
        @(posedge clk); #1;
        exp_cnt++;
        check({name, " count"}, 64'(bus.instr_count), 64'(exp_cnt));
        check({name, " count2"}, 64'(bus2.instr_count), 64'(exp_cnt[1:0]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(6'b000000, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("reset strobes", 64'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.MemRead}), 64'(0));
        check("reset state", 64'({bus.state, bus.halted}), 64'({S_IF, 1'b0}));
        check("reset count", 64'(bus.instr_count), 64'(0));
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic run_halt(input logic [5:0] op);
        set_in(op, 1'b0);
        @(negedge clk);
        check($sformatf("halt%b IF", op), 64'({bus.state, bus.IRWrite, bus.InsMemRW}), 64'({S_IF, 2'b11}));
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("halt%b ID", op),
              64'({bus.state, bus.PCWrite, bus.IRWrite, bus.InsMemRW, bus.halted}), 64'({S_ID, 4'b0000}));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("halt%b hold%0d", op, i),
                  64'({bus.PCWrite, bus.IRWrite, bus.InsMemRW, bus.MemRead, bus.MemWrite,
                       bus.RegWrite, bus.MemtoReg, bus.halted}), 64'(8'b0000_0001));
        end
        check($sformatf("halt%b count", op), 64'(bus.instr_count), 64'(exp_cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        add(6'b000000, 1'b0, 4, S_AL, S_WBAL, S_IF, 4'b1000, 1'b1, 2'b00, 1'b1);
        add(6'b100011, 1'b0, 5, S_LS, S_MEM, S_WBLD, 4'b0000, 1'b1, 2'b00, 1'b0);
        add(6'b101011, 1'b0, 4, S_LS, S_MEM, S_IF, 4'b0000, 1'b1, 2'b00, 1'b0);
        add(6'b000100, 1'b1, 3, S_BR, S_IF, S_IF, 4'b0001, 1'b1, 2'b01, 1'b0);
        add(6'b000101, 1'b1, 3, S_BR, S_IF, S_IF, 4'b0001, 1'b1, 2'b00, 1'b0);
        add(6'b000110, 1'b0, 3, S_BR, S_IF, S_IF, 4'b0100, 1'b1, 2'b00, 1'b0);
        add(6'b000101, 1'b0, 3, S_BR, S_IF, S_IF, 4'b0001, 1'b1, 2'b01, 1'b0);
        add(6'b000110, 1'b1, 3, S_BR, S_IF, S_IF, 4'b0100, 1'b1, 2'b01, 1'b0);
        add(6'b000100, 1'b0, 3, S_BR, S_IF, S_IF, 4'b0001, 1'b1, 2'b00, 1'b0);
        add(6'b000010, 1'b0, 2, S_IF, S_IF, S_IF, 4'b0000, 1'b1, 2'b10, 1'b0);
        add(6'b001001, 1'b0, 4, S_AL, S_WBAL, S_IF, 4'b0000, 1'b1, 2'b00, 1'b0);
        add(6'b001100, 1'b0, 4, S_AL, S_WBAL, S_IF, 4'b0010, 1'b0, 2'b00, 1'b0);
        add(6'b001101, 1'b0, 4, S_AL, S_WBAL, S_IF, 4'b0011, 1'b0, 2'b00, 1'b0);
        add(6'b001010, 1'b0, 4, S_AL, S_WBAL, S_IF, 4'b0100, 1'b1, 2'b00, 1'b0);

        do_reset();
        foreach (vecs[i]) run_vec(vecs[i]);

        run_halt(6'b111111);
        do_reset();
        run_halt(6'b010101);
        do_reset();

        // Reset landing in the MEM cycle of sw must suppress the store and the retire.
        v = vecs[2];
        run_cycles(v, 3, "sw-rst");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("sw-rst MEM strobes", 64'({bus.state, bus.MemWrite, bus.PCWrite}), 64'({S_MEM, 2'b00}));
        @(posedge clk); #1;
        check("sw-rst state", 64'(bus.state), 64'(S_IF));
        check("sw-rst count", 64'(bus.instr_count), 64'(0));
        check("sw-rst count2", 64'(bus2.instr_count), 64'(0));
        rst     = 1'b0;
        exp_cnt = '0;

        for (int i = 0; i < 5; i++) run_vec(vecs[9]);
        check("wrap count2", 64'(bus2.instr_count), 64'(1));
        check("wrap count", 64'(bus.instr_count), 64'(5));
        check("scoreboard empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
